// File: rtl/led_cmd_arbiter.sv
// Round-robin arbiter that shares one LED blinker command port between N_REQ requesters.
// Each grant issues a held valid pulse followed by a dwell window; duplicate modes are acked only.
module led_cmd_arbiter #(
  parameter  int N_REQ     = 3,
  parameter  int PULSE_LEN = 10,
  parameter  int DWELL_LEN = 10,
  parameter  bit SKIP_DUP  = 1'b1,
  localparam int IDW       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [N_REQ-1:0]   req_valid_i,
  input  logic [2*N_REQ-1:0] req_mode_i,
  output logic [N_REQ-1:0]   req_ready_o,
  output logic [1:0]         cmd_data_o,
  output logic               cmd_valid_o,
  output logic [1:0]         cur_mode_o,
  output logic [IDW-1:0]     grant_id_o,
  output logic               busy_o
);

  // state | meaning
  // IDLE  | waiting for a request, grant sampled here
  // ISSUE | cmd_valid held for PULSE_LEN cycles
  // DWELL | mode held, requests ignored for DWELL_LEN cycles
  // SKIP  | one-cycle ack of a request equal to the current mode
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DWELL = 2'd2;
  localparam logic [1:0] S_SKIP  = 2'd3;

  localparam int CNT_MAX = (PULSE_LEN > DWELL_LEN) ? PULSE_LEN : DWELL_LEN;
  localparam int CW      = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   gid_q, gid_d;
  logic [1:0]       mode_q, mode_d;
  logic [N_REQ-1:0] ready_q, ready_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;

  logic [1:0]       mode_arr [N_REQ];
  logic [IDW:0]     scan;
  logic [IDW-1:0]   gsel;
  logic             found;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_mode
    assign mode_arr[gi] = req_mode_i[2*gi +: 2];
  end

  // First pending requester at or above the pointer, wrapping at N_REQ.
  always_comb begin
    found = 1'b0;
    gsel  = '0;
    scan  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan = {1'b0, ptr_q} + (IDW+1)'(k);
      if (scan >= (IDW+1)'(N_REQ)) scan = scan - (IDW+1)'(N_REQ);
      if (!found && req_valid_i[scan[IDW-1:0]]) begin
        found = 1'b1;
        gsel  = scan[IDW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    mode_d  = mode_q;
    ready_d = '0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          gid_d   = gsel;
          ptr_d   = (gsel == IDW'(N_REQ - 1)) ? '0 : gsel + IDW'(1);
          ready_d = N_REQ'(1) << gsel;
          if (SKIP_DUP && (mode_arr[gsel] == mode_q)) begin
            state_d = S_SKIP;
          end else begin
            state_d = S_ISSUE;
            mode_d  = mode_arr[gsel];
            cnt_d   = CW'(PULSE_LEN);
          end
        end
      end
      S_ISSUE: begin
        if (cnt_q <= CW'(1)) begin
          if (DWELL_LEN == 0) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DWELL;
            cnt_d   = CW'(DWELL_LEN);
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DWELL: begin
        if (cnt_q <= CW'(1)) state_d = S_IDLE;
        else                 cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = S_IDLE;
    endcase
    valid_d = (state_d == S_ISSUE);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      gid_q   <= '0;
      mode_q  <= '0;
      ready_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      mode_q  <= mode_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign req_ready_o = ready_q;
  assign cmd_data_o  = mode_q;
  assign cmd_valid_o = valid_q;
  assign cur_mode_o  = mode_q;
  assign grant_id_o  = gid_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_led_cmd_arbiter.sv
// Bench for led_cmd_arbiter: two instances (default timing, and short pulse with no dwell)
// driven by random requesters and checked every cycle against a grant-schedule model.
module tb_led_cmd_arbiter;

  localparam int N = 3;
  localparam int NCYC = 1500;

  logic clk = 1'b0;
  logic rst;

  logic [N-1:0]   rv  [2];
  logic [2*N-1:0] rm  [2];
  logic [N-1:0]   rdy [2];
  logic [1:0]     cd  [2];
  logic           cv  [2];
  logic [1:0]     cm  [2];
  logic [1:0]     gi  [2];
  logic           bz  [2];

  always #5 clk = ~clk;

  led_cmd_arbiter #(.N_REQ(N), .PULSE_LEN(10), .DWELL_LEN(10), .SKIP_DUP(1'b1)) dut_a (
    .clk_i(clk), .rst_i(rst), .req_valid_i(rv[0]), .req_mode_i(rm[0]),
    .req_ready_o(rdy[0]), .cmd_data_o(cd[0]), .cmd_valid_o(cv[0]),
    .cur_mode_o(cm[0]), .grant_id_o(gi[0]), .busy_o(bz[0]));

  led_cmd_arbiter #(.N_REQ(N), .PULSE_LEN(3), .DWELL_LEN(0), .SKIP_DUP(1'b1)) dut_b (
    .clk_i(clk), .rst_i(rst), .req_valid_i(rv[1]), .req_mode_i(rm[1]),
    .req_ready_o(rdy[1]), .cmd_data_o(cd[1]), .cmd_valid_o(cv[1]),
    .cur_mode_o(cm[1]), .grant_id_o(gi[1]), .busy_o(bz[1]));

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: a grant at sample k issues a pulse for samples k..k+P-1 and keeps
  // the arbiter busy until k+P+D-1; the next grant can be sampled two later.
  int plen [2] = '{10, 3};
  int dlen [2] = '{10, 0};
  int busy_end [2];
  int valid_end [2];
  int ptr [2];
  int issue_k [2];
  logic [1:0]   cur [2];
  logic [1:0]   gid [2];
  logic [N-1:0] e_ready [2];
  logic         e_valid [2];
  logic         e_busy [2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      busy_end[i] = -10; valid_end[i] = -10; ptr[i] = 0; issue_k[i] = -100;
      cur[i] = 2'b00; gid[i] = 2'b00;
      e_ready[i] = '0; e_valid[i] = 1'b0; e_busy[i] = 1'b0;
    end
  endtask

  task automatic model_step(input int i, input int k);
    int g;
    logic [N-1:0]   sh;
    logic [2*N-1:0] msh;
    logic [1:0]     m;
    e_ready[i] = '0;
    if (k >= busy_end[i] + 2 && rv[i] != '0) begin
      g = -1;
      for (int s = 0; s < N; s++) begin
        sh = rv[i] >> ((ptr[i] + s) % N);
        if (g < 0 && sh[0]) g = (ptr[i] + s) % N;
      end
      msh = rm[i] >> (2 * g);
      m = msh[1:0];
      e_ready[i] = N'(1) << g;
      gid[i] = 2'(g);
      ptr[i] = (g + 1) % N;
      if (m == cur[i]) begin
        busy_end[i] = k;
      end else begin
        cur[i] = m;
        issue_k[i] = k;
        valid_end[i] = k + plen[i] - 1;
        busy_end[i] = k + plen[i] + dlen[i] - 1;
      end
    end
    e_valid[i] = (k <= valid_end[i]);
    e_busy[i]  = (k <= busy_end[i]);
  endtask

  task automatic check_outputs(input string ph);
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("%s_i%0d_valid", ph, i), 32'(cv[i]),  32'(e_valid[i]));
      check_eq($sformatf("%s_i%0d_data",  ph, i), 32'(cd[i]),  32'(cur[i]));
      check_eq($sformatf("%s_i%0d_cur",   ph, i), 32'(cm[i]),  32'(cur[i]));
      check_eq($sformatf("%s_i%0d_ready", ph, i), 32'(rdy[i]), 32'(e_ready[i]));
      check_eq($sformatf("%s_i%0d_busy",  ph, i), 32'(bz[i]),  32'(e_busy[i]));
      check_eq($sformatf("%s_i%0d_gid",   ph, i), 32'(gi[i]),  32'(gid[i]));
    end
  endtask

  // Requesters: drop on acknowledge, rarely withdraw early, randomly raise new requests.
  task automatic drive_agents(input bit random_on);
    logic [N-1:0]   bm;
    logic [2*N-1:0] mm;
    for (int i = 0; i < 2; i++) begin
      for (int r = 0; r < N; r++) begin
        bm = N'(1) << r;
        mm = (2*N)'(3) << (2 * r);
        if ((rv[i] & bm) != '0) begin
          if ((rdy[i] & bm) != '0) rv[i] = rv[i] & ~bm;
          else if (random_on && $urandom_range(0, 49) == 0) rv[i] = rv[i] & ~bm;
        end else if (random_on && $urandom_range(0, 9) == 0) begin
          rv[i] = rv[i] | bm;
          rm[i] = (rm[i] & ~mm) | (((2*N)'($urandom_range(0, 3))) << (2 * r));
        end
      end
    end
  endtask

  initial begin
    bit rst_done;
    int pk;
    rst_done = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin rv[i] = '0; rm[i] = '0; end
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs("reset");
    rst = 1'b0;

    // Requester 1 asks for mode 01 on both instances right after reset.
    rv[0] = 3'b010; rm[0] = 6'b000100;
    rv[1] = 3'b010; rm[1] = 6'b000100;

    pk = 0;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      if (cyc > 0) drive_agents(cyc >= 40);
      if (!rst_done && cyc > 700 && cyc == issue_k[0] + 4) begin
        rst_done = 1'b1;
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
          check_eq($sformatf("async_rst_i%0d_valid", i), 32'(cv[i]),  32'(0));
          check_eq($sformatf("async_rst_i%0d_busy",  i), 32'(bz[i]),  32'(0));
          check_eq($sformatf("async_rst_i%0d_ready", i), 32'(rdy[i]), 32'(0));
          check_eq($sformatf("async_rst_i%0d_cur",   i), 32'(cm[i]),  32'(0));
        end
        model_reset();
        @(negedge clk);
        check_outputs("in_rst");
        rst = 1'b0;
      end
      model_step(0, pk);
      model_step(1, pk);
      @(posedge clk);
      @(negedge clk);
      check_outputs("run");
      pk++;
    end

    check_eq("reset_mid_issue_reached", 32'(rst_done), 32'(1));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
